// File: rtl/goldschmidt_seq_pkg.sv
// Shared encodings and step-control payload for the Goldschmidt divide/sqrt sequencer.
package goldschmidt_seq_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_SQRT = 2'b01;

  localparam logic [CNT_W-1:0] DIV_LAST  = 4'd11;
  localparam logic [CNT_W-1:0] SQRT_LAST = 4'd15;

  // Operand mux select codes shared by sA and sB
  localparam logic [1:0] SEL_PASS     = 2'b00;
  localparam logic [1:0] SEL_ITER     = 2'b01;
  localparam logic [1:0] SEL_MODE     = 2'b10;
  localparam logic [1:0] SEL_MODE_ODD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] sa;
    logic [1:0] sb;
    logic       sq_sel;
    logic       en_n;
    logic       en_d;
    logic       en_k;
    logic       en_qd;
  } step_ctrl_t;

  function automatic logic is_div(input logic [1:0] op);
    return op == OP_DIV;
  endfunction

  function automatic logic [CNT_W-1:0] last_step(input logic [1:0] op);
    return is_div(op) ? DIV_LAST : SQRT_LAST;
  endfunction

endpackage

// File: rtl/goldschmidt_seq_if.sv
// Request/result handshake bundle between a client and the sequencer.
interface goldschmidt_seq_if #(
  parameter int unsigned SIZE = 30
);
  logic            start;
  logic [1:0]      op_in;
  logic            ready;
  logic            busy;
  logic [SIZE-1:0] res_data;
  logic            res_sign;
  logic            res_valid;
  logic            res_ready;

  modport master (
    output start, op_in, res_ready,
    input  ready, busy, res_data, res_sign, res_valid
  );

  modport slave (
    input  start, op_in, res_ready,
    output ready, busy, res_data, res_sign, res_valid
  );
endinterface

// File: rtl/goldschmidt_seq_step_decode.sv
// Combinational map from (op, step count) to datapath selects and register enables.
module gs_step_decode
  import goldschmidt_seq_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] cnt,
  input  logic             running,
  output step_ctrl_t       ctrl
);

  logic       rem;
  logic       mode;
  logic       stage;
  logic [1:0] phase;

  always_comb begin
    ctrl  = '0;
    rem   = 1'b0;
    mode  = 1'b0;
    stage = 1'b0;
    phase = 2'(cnt % 4'd3);
    if (running) begin
      if (is_div(op)) begin
        rem        = (cnt == DIV_LAST);
        mode       = (cnt >= 4'd2) && (cnt <= 4'd10);
        stage      = cnt[0];
        ctrl.sa    = {rem, mode};
        ctrl.sb    = {mode, stage};
        ctrl.en_n  = ~stage;
        ctrl.en_d  = stage;
        ctrl.en_k  = stage;
        ctrl.en_qd = rem;
      end else begin
        // Enables cycle N, K, D+K; the three-step iteration proper starts at cnt 3
        ctrl.en_n = (phase == 2'd0);
        ctrl.en_k = (phase != 2'd0);
        ctrl.en_d = (phase == 2'd2);
        if (cnt == 4'd1) begin
          ctrl.sq_sel = 1'b1;
        end else if (cnt == 4'd2) begin
          ctrl.sa = SEL_ITER;
        end else if (cnt >= 4'd3) begin
          ctrl.sa = SEL_ITER;
          case (phase)
            2'd0:    ctrl.sb = SEL_MODE;
            2'd1:    ctrl.sq_sel = 1'b1;
            default: ctrl.sb = SEL_MODE_ODD;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/goldschmidt_seq.sv
// Goldschmidt divide/square-root sequencer: steps the datapath and buffers one result.
module goldschmidt_seq
  import goldschmidt_seq_pkg::*;
#(
  parameter  int unsigned LEADS = 2,
  parameter  int unsigned WIDTH = 28,
  localparam int unsigned SIZE  = LEADS + WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  goldschmidt_seq_if.slave bus,
  output logic [1:0]      op,
  output logic [1:0]      sA,
  output logic [1:0]      sB,
  output logic            sq_sel,
  output logic            enableN,
  output logic            enableD,
  output logic            enableK,
  output logic            enableQD,
  input  logic [SIZE-1:0] result_in,
  input  logic            r_sign_in
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tail, tail_nxt;
  logic [1:0]       op_nxt;
  logic             busy_q, busy_nxt;
  logic [SIZE-1:0]  res_data_q, res_data_nxt;
  logic             res_sign_q, res_sign_nxt;
  logic             res_valid_q, res_valid_nxt;
  logic             ready_c;
  step_ctrl_t       step_c, step_q;

  assign ready_c       = (state == IDLE) && (!res_valid_q || bus.res_ready);
  assign bus.ready     = ready_c;
  assign bus.busy      = busy_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_sign  = res_sign_q;
  assign bus.res_valid = res_valid_q;

  assign sA       = step_q.sa;
  assign sB       = step_q.sb;
  assign sq_sel   = step_q.sq_sel;
  assign enableN  = step_q.en_n;
  assign enableD  = step_q.en_d;
  assign enableK  = step_q.en_k;
  assign enableQD = step_q.en_qd;

  // Controls are registered, so RUN keeps one tail cycle to let the last step land
  gs_step_decode u_decode (
    .op      (op),
    .cnt     (cnt),
    .running ((state == RUN) && !tail),
    .ctrl    (step_c)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tail_nxt      = tail;
    op_nxt        = op;
    busy_nxt      = busy_q;
    res_data_nxt  = res_data_q;
    res_sign_nxt  = res_sign_q;
    res_valid_nxt = res_valid_q && !bus.res_ready;
    case (state)
      IDLE: begin
        if (bus.start && ready_c) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          tail_nxt  = 1'b0;
          op_nxt    = bus.op_in;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (tail) begin
          state_nxt = WB;
          tail_nxt  = 1'b0;
        end else if (cnt == last_step(op)) begin
          tail_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WB: begin
        state_nxt     = IDLE;
        busy_nxt      = 1'b0;
        res_data_nxt  = result_in;
        res_sign_nxt  = is_div(op) ? r_sign_in : 1'b0;
        res_valid_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tail        <= 1'b0;
      op          <= OP_DIV;
      busy_q      <= 1'b0;
      res_data_q  <= '0;
      res_sign_q  <= 1'b0;
      res_valid_q <= 1'b0;
      step_q      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tail        <= tail_nxt;
      op          <= op_nxt;
      busy_q      <= busy_nxt;
      res_data_q  <= res_data_nxt;
      res_sign_q  <= res_sign_nxt;
      res_valid_q <= res_valid_nxt;
      step_q      <= step_c;
    end
  end

endmodule

// File: tb/tb_goldschmidt_seq.sv
// Randomized bench for goldschmidt_seq against a step-table and latency model.
module tb_goldschmidt_seq;

  localparam int unsigned SIZE = 30;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      op;
  logic [1:0]      sA, sB;
  logic            sq_sel, enableN, enableD, enableK, enableQD;
  logic [SIZE-1:0] result_in;
  logic            r_sign_in;
  logic [8:0]      ctrl_obs;

  goldschmidt_seq_if #(.SIZE(SIZE)) bus ();

  goldschmidt_seq #(.LEADS(2), .WIDTH(28)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .op        (op),
    .sA        (sA),
    .sB        (sB),
    .sq_sel    (sq_sel),
    .enableN   (enableN),
    .enableD   (enableD),
    .enableK   (enableK),
    .enableQD  (enableQD),
    .result_in (result_in),
    .r_sign_in (r_sign_in)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {sA, sB, sq_sel, enableN, enableD, enableK, enableQD};

  int              n_vec = 0;
  int              n_err = 0;
  bit              pend;
  logic [SIZE-1:0] pend_data;
  logic            pend_sign;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {sA,sB,sq_sel,N,D,K,QD} for step k of an operation
  function automatic logic [8:0] exp_step(input logic [1:0] o, input int k);
    logic [1:0] sa, sb;
    logic       sq, n, d, kk, qd, rem, mode, st;
    sa = 2'b00; sb = 2'b00; sq = 1'b0; n = 1'b0; d = 1'b0; kk = 1'b0; qd = 1'b0;
    if (o == 2'b00) begin
      rem  = (k == 11);
      mode = (k >= 2) && (k <= 10);
      st   = (k % 2) == 1;
      sa = {rem, mode}; sb = {mode, st};
      n = !st; d = st; kk = st; qd = rem;
    end else begin
      n  = (k % 3) == 0;
      kk = (k % 3) != 0;
      d  = (k % 3) == 2;
      if (k == 1) sq = 1'b1;
      else if (k == 2) sa = 2'b01;
      else if (k >= 3) begin
        sa = 2'b01;
        case ((k - 3) % 3)
          0:       sb = 2'b10;
          1:       sq = 1'b1;
          default: sb = 2'b11;
        endcase
      end
    end
    return {sa, sb, sq, n, d, kk, qd};
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctrl"}, ctrl_obs, 9'd0);
    chk({tag, "_op"}, op, 2'b00);
    chk({tag, "_data"}, bus.res_data, '0);
    chk({tag, "_sign"}, bus.res_sign, 1'b0);
    chk({tag, "_valid"}, bus.res_valid, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_ready"}, bus.ready, 1'b1);
  endtask

  task automatic run_op(input logic [1:0] o);
    int              last;
    int              stalls;
    logic [SIZE-1:0] rd;
    logic            rs;
    last = (o == 2'b00) ? 11 : 15;
    if (pend) begin
      stalls = $urandom_range(0, 3);
      for (int s = 0; s < stalls; s++) begin
        bus.start = 1'b1; bus.op_in = 2'($urandom); bus.res_ready = 1'b0;
        #1;
        chk("bp_ready", bus.ready, 1'b0);
        tick;
        chk("bp_busy", bus.busy, 1'b0);
        chk("bp_valid", bus.res_valid, 1'b1);
        chk("bp_data", bus.res_data, pend_data);
        chk("bp_sign", bus.res_sign, pend_sign);
      end
    end
    bus.start = 1'b1; bus.op_in = o; bus.res_ready = 1'b1;
    #1;
    chk("acc_ready", bus.ready, 1'b1);
    tick;
    bus.start = 1'b0; bus.res_ready = 1'b0;
    chk("acc_pop", bus.res_valid, 1'b0);
    chk("acc_busy", bus.busy, 1'b1);
    chk("acc_op", op, o);
    for (int k = 0; k <= last; k++) begin
      bus.op_in = 2'($urandom);
      result_in = SIZE'($urandom);
      r_sign_in = 1'($urandom);
      tick;
      chk($sformatf("op%0d_step%0d", o, k), ctrl_obs, exp_step(o, k));
      if (k == last) chk("run_op_hold", op, o);
    end
    rd = SIZE'($urandom); rs = 1'($urandom);
    tick;
    chk("wb_ctrl", ctrl_obs, 9'd0);
    chk("wb_valid", bus.res_valid, 1'b0);
    result_in = rd; r_sign_in = rs;
    tick;
    result_in = SIZE'($urandom); r_sign_in = 1'($urandom);
    chk("done_valid", bus.res_valid, 1'b1);
    chk("done_data", bus.res_data, rd);
    chk("done_sign", bus.res_sign, (o == 2'b00) ? rs : 1'b0);
    chk("done_busy", bus.busy, 1'b0);
    chk("done_ctrl", ctrl_obs, 9'd0);
    pend = 1'b1;
    pend_data = rd;
    pend_sign = (o == 2'b00) ? rs : 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op_in = 2'b00; bus.res_ready = 1'b0;
    result_in = '0; r_sign_in = 1'b0;
    pend = 1'b0; pend_data = '0; pend_sign = 1'b0;
    tick; tick;
    chk_reset_state("por");
    reset = 1'b0;
    tick;

    run_op(2'b00);
    run_op(2'b01);
    for (int i = 0; i < 10; i++) run_op(2'($urandom));

    // Abandon a divide mid-run
    bus.start = 1'b1; bus.op_in = 2'b00; bus.res_ready = 1'b1;
    tick;
    bus.start = 1'b0; bus.res_ready = 1'b0;
    repeat (6) tick;
    chk("mid_step5", ctrl_obs, exp_step(2'b00, 5));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_reset_state("mid_rst");
    pend = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (i % 5 == 0) begin
        chk("post_rst_valid", bus.res_valid, 1'b0);
        chk("post_rst_busy", bus.busy, 1'b0);
      end
    end
    run_op(2'b01);
    run_op(2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
